// File: rtl/cnn_acc_pkg.sv
// Shared width helpers and types for the CNN adder-tree accumulator.
package cnn_acc_pkg;

  // Default operand count and width used across the accelerator datapath.
  localparam int unsigned CnnNIn = 6;
  localparam int unsigned CnnInW = 6;

  typedef enum logic [0:0] {StIdle, StAccum} acc_state_e;

  function automatic int unsigned tree_depth(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned sum_w(input int unsigned in_w, input int unsigned n);
    return in_w + tree_depth(n);
  endfunction

  function automatic int unsigned out_w(input int unsigned in_w, input int unsigned n,
                                        input int unsigned acc_len);
    return sum_w(in_w, n) + $clog2(acc_len);
  endfunction

  // Number of entries present at tree level k (level 0 = extended operands).
  function automatic int unsigned level_count(input int unsigned n, input int unsigned k);
    int unsigned c;
    c = n;
    for (int unsigned i = 0; i < k; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // Bit offset of level k inside the flattened tree bus.
  function automatic int unsigned level_offset(input int unsigned n, input int unsigned k,
                                               input int unsigned w);
    int unsigned off;
    off = 0;
    for (int unsigned i = 0; i < k; i++) off += level_count(n, i) * w;
    return off;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered adder-tree level: sums adjacent pairs, forwards an odd leftover.
module adder_tree_level #(
  parameter int unsigned NumIn = 2,
  parameter int unsigned Width = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               enable_i,
  input  logic                               valid_i,
  input  logic                               last_i,
  input  logic [NumIn*Width-1:0]             data_i,
  output logic                               valid_o,
  output logic                               last_o,
  output logic [((NumIn+1)/2)*Width-1:0]     data_o
);

  localparam int unsigned NumOut = (NumIn + 1) / 2;

  logic [NumOut*Width-1:0] data_d, data_q;
  logic                    valid_q, last_q;

  // Pairwise sums; the trailing entry of an odd-sized level passes through unchanged.
  always_comb begin
    data_d = '0;
    for (int unsigned i = 0; i < NumOut; i++) begin
      if (2 * i + 1 < NumIn) begin
        data_d[i*Width +: Width] = data_i[2*i*Width +: Width] + data_i[(2*i+1)*Width +: Width];
      end else begin
        data_d[i*Width +: Width] = data_i[2*i*Width +: Width];
      end
    end
  end

  // Level register; frozen entirely while enable is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (enable_i) begin
      data_q  <= data_d;
      valid_q <= valid_i;
      last_q  <= last_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;

endmodule

// File: rtl/adder_tree_accum.sv
// Pipelined N-input adder tree followed by a multi-beat accumulator with valid/last sideband.
module adder_tree_accum
  import cnn_acc_pkg::*;
#(
  parameter int unsigned N_IN    = CnnNIn,
  parameter int unsigned IN_W    = CnnInW,
  parameter int unsigned ACC_LEN = 4,
  parameter bit          SIGNED  = 1'b0,
  localparam int unsigned OUT_W  = out_w(IN_W, N_IN, ACC_LEN),
  localparam int unsigned CNT_W  = $clog2(ACC_LEN) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   in_valid_i,
  input  logic                   in_last_i,
  input  logic [N_IN*IN_W-1:0]   in_data_i,
  output logic                   out_valid_o,
  output logic [OUT_W-1:0]       out_data_o,
  output logic [CNT_W-1:0]       out_beats_o
);

  localparam int unsigned D     = tree_depth(N_IN);
  localparam int unsigned SUM_W = sum_w(IN_W, N_IN);
  localparam int unsigned BUS_W = level_offset(N_IN, D + 1, SUM_W);

  // All tree levels packed back to back; level 0 is the registered, extended operand set.
  logic [BUS_W-1:0]       tree_bus;
  logic [D:0]             tree_valid, tree_last;
  logic [N_IN*SUM_W-1:0]  ent_d, ent_q;
  logic                   ent_valid_q, ent_last_q;
  logic [SUM_W-1:0]       tree_sum;
  logic [OUT_W-1:0]       sum_ext, acc_new;
  logic                   closing;

  acc_state_e             state_d, state_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;
  logic [OUT_W-1:0]       acc_d, acc_q;
  logic [OUT_W-1:0]       out_data_d, out_data_q;
  logic [CNT_W-1:0]       out_beats_d, out_beats_q;
  logic                   out_valid_d, out_valid_q;

  for (genvar i = 0; i < N_IN; i++) begin : g_ext
    logic [IN_W-1:0] op;
    assign op = in_data_i[i*IN_W +: IN_W];
    if (SIGNED) begin : g_sign
      assign ent_d[i*SUM_W +: SUM_W] = SUM_W'(signed'(op));
    end else begin : g_zero
      assign ent_d[i*SUM_W +: SUM_W] = SUM_W'(op);
    end
  end

  // Entry register; last is only meaningful alongside valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ent_q       <= '0;
      ent_valid_q <= 1'b0;
      ent_last_q  <= 1'b0;
    end else if (enable_i) begin
      ent_q       <= ent_d;
      ent_valid_q <= in_valid_i;
      ent_last_q  <= in_valid_i & in_last_i;
    end
  end

  assign tree_bus[N_IN*SUM_W-1:0] = ent_q;
  assign tree_valid[0]            = ent_valid_q;
  assign tree_last[0]             = ent_last_q;

  for (genvar k = 0; k < D; k++) begin : g_level
    localparam int unsigned NIn    = level_count(N_IN, k);
    localparam int unsigned NOut   = level_count(N_IN, k + 1);
    localparam int unsigned OffIn  = level_offset(N_IN, k, SUM_W);
    localparam int unsigned OffOut = level_offset(N_IN, k + 1, SUM_W);

    adder_tree_level #(
      .NumIn (NIn),
      .Width (SUM_W)
    ) u_level (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .enable_i (enable_i),
      .valid_i  (tree_valid[k]),
      .last_i   (tree_last[k]),
      .data_i   (tree_bus[OffIn +: NIn*SUM_W]),
      .valid_o  (tree_valid[k+1]),
      .last_o   (tree_last[k+1]),
      .data_o   (tree_bus[OffOut +: NOut*SUM_W])
    );
  end

  assign tree_sum = tree_bus[level_offset(N_IN, D, SUM_W) +: SUM_W];

  if (SIGNED) begin : g_acc_sign
    assign sum_ext = OUT_W'(signed'(tree_sum));
  end else begin : g_acc_zero
    assign sum_ext = OUT_W'(tree_sum);
  end

  // Accumulator FSM: start a fresh sum in StIdle, close on count reached or last.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    out_valid_d = 1'b0;
    acc_new     = (state_q == StIdle) ? sum_ext : acc_q + sum_ext;
    closing     = tree_last[D] || (cnt_q == CNT_W'(ACC_LEN - 1));
    if (tree_valid[D]) begin
      acc_d = acc_new;
      if (closing) begin
        out_data_d  = acc_new;
        out_beats_d = cnt_q + CNT_W'(1);
        out_valid_d = 1'b1;
        cnt_d       = '0;
        state_d     = StIdle;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = StAccum;
      end
    end
  end

  // Accumulator and output registers; a pending pulse survives a stall and is shown on resume.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_beats_q <= '0;
      out_valid_q <= 1'b0;
    end else if (enable_i) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid_o = out_valid_q & enable_i;
  assign out_data_o  = out_data_q;
  assign out_beats_o = out_beats_q;

endmodule

// File: tb/tb_adder_tree_accum.sv
// Self-checking bench: directed group table, async reset, stall, random scoreboard, signed/odd-N.
module tb_adder_tree_accum;

  localparam int A0 = 4;
  localparam logic [35:0] All63 = {6{6'd63}};
  localparam logic [35:0] All2  = {6{6'd2}};
  localparam logic [35:0] AllM32 = {6{6'h20}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Default instance
  logic        en0, v0, l0;
  logic [35:0] d0;
  logic        ov0;
  logic [10:0] od0;
  logic [2:0]  ob0;
  // Signed, ACC_LEN=1 instance and odd N_IN instance share enable/last
  logic        en1, l1, v1, v2;
  logic [35:0] d1;
  logic [29:0] d2;
  logic        ov1, ov2;
  logic [8:0]  od1, od2;
  logic [0:0]  ob1, ob2;

  adder_tree_accum u_dut0 (
    .clk_i(clk), .rst_i(rst), .enable_i(en0), .in_valid_i(v0), .in_last_i(l0),
    .in_data_i(d0), .out_valid_o(ov0), .out_data_o(od0), .out_beats_o(ob0)
  );

  adder_tree_accum #(.N_IN(6), .IN_W(6), .ACC_LEN(1), .SIGNED(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en1), .in_valid_i(v1), .in_last_i(l1),
    .in_data_i(d1), .out_valid_o(ov1), .out_data_o(od1), .out_beats_o(ob1)
  );

  adder_tree_accum #(.N_IN(5), .IN_W(6), .ACC_LEN(1), .SIGNED(1'b0)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .enable_i(en1), .in_valid_i(v2), .in_last_i(l1),
    .in_data_i(d2), .out_valid_o(ov2), .out_data_o(od2), .out_beats_o(ob2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: results described as whole groups of beat sums.
  typedef struct { int data; int beats; } res_t;
  res_t expq[$];
  int   acc_m = 0;
  int   cnt_m = 0;

  function automatic int sum_u(input logic [35:0] d, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(d[i*6 +: 6]);
    return s;
  endfunction

  function automatic int sum_s(input logic [35:0] d);
    int s = 0;
    for (int i = 0; i < 6; i++) s += int'($signed(d[i*6 +: 6]));
    return s;
  endfunction

  task automatic model_beat(input logic [35:0] d, input logic l);
    res_t r;
    acc_m += sum_u(d, 6);
    cnt_m++;
    if (cnt_m == A0 || l) begin
      r.data  = acc_m;
      r.beats = cnt_m;
      expq.push_back(r);
      acc_m = 0;
      cnt_m = 0;
    end
  endtask

  int seen = 0;
  int pulse_cyc, pulse_data, pulse_beats;

  task automatic monitor0();
    res_t r;
    if (!en0) chk("stall_quiet", int'(ov0), 0);
    if (ov0) begin
      seen        = 1;
      pulse_cyc   = cyc;
      pulse_data  = int'(od0);
      pulse_beats = int'(ob0);
      chk("sb_pending", int'(expq.size() > 0), 1);
      if (expq.size() > 0) begin
        r = expq.pop_front();
        chk("sb_data", int'(od0), r.data);
        chk("sb_beats", int'(ob0), r.beats);
      end
    end
  endtask

  // Drive one cycle of dut0 input after the edge, then check outputs on the falling edge.
  task automatic step(input logic en, input logic v, input logic l, input logic [35:0] d);
    @(posedge clk);
    #1;
    en0 = en; v0 = v; l0 = l; d0 = d;
    if (en && v) model_beat(d, l);
    @(negedge clk);
    monitor0();
  endtask

  typedef struct {
    int              nbeats;
    logic [3:0][35:0] beat;
    logic            use_last;
    int              stall_at;
    int              exp_data;
    int              exp_beats;
    int              exp_lat;
  } grp_t;

  function automatic grp_t mk(input int n, input logic [35:0] b0, input logic [35:0] b1,
                              input logic [35:0] b2, input logic [35:0] b3, input logic ul,
                              input int st, input int ed, input int eb, input int el);
    grp_t g;
    g.nbeats = n; g.beat[0] = b0; g.beat[1] = b1; g.beat[2] = b2; g.beat[3] = b3;
    g.use_last = ul; g.stall_at = st; g.exp_data = ed; g.exp_beats = eb; g.exp_lat = el;
    return g;
  endfunction

  // Latency is measured from the first beat's sample edge to the visible pulse.
  task automatic run_group(input grp_t g, input string tag);
    int t_first = 0;
    seen = 0;
    for (int b = 0; b < g.nbeats; b++) begin
      if (g.stall_at != 0 && b == g.stall_at) begin
        for (int s = 0; s < 3; s++) step(1'b0, 1'b1, 1'b0, All63);
      end
      step(1'b1, 1'b1, g.use_last && (b == g.nbeats - 1), g.beat[b]);
      if (b == 0) t_first = cyc + 1;
    end
    for (int n = 0; n < 24 && seen == 0; n++) step(1'b1, 1'b0, 1'b0, '0);
    chk({tag, "_seen"}, seen, 1);
    chk({tag, "_lat"}, pulse_cyc - t_first, g.exp_lat);
    chk({tag, "_data"}, pulse_data, g.exp_data);
    chk({tag, "_beats"}, pulse_beats, g.exp_beats);
  endtask

  grp_t tbl[6];
  logic [35:0] b1[24];
  logic [29:0] b2[24];
  int          e1[24];
  int          e2[24];

  initial begin
    logic [63:0] rnd;
    en0 = 1'b1; v0 = 1'b0; l0 = 1'b0; d0 = '0;
    en1 = 1'b1; l1 = 1'b0; v1 = 1'b0; v2 = 1'b0; d1 = '0; d2 = '0;

    tbl[0] = mk(4, All63, All63, All63, All63, 1'b0, 0, 1512, 4, 7);
    tbl[1] = mk(3, 36'd10, 36'd20, 36'd5, 36'd0, 1'b1, 0, 35, 3, 6);
    tbl[2] = mk(4, 36'd1, 36'd1, 36'd1, 36'd1, 1'b0, 0, 4, 4, 7);
    tbl[3] = mk(1, 36'd42, 36'd0, 36'd0, 36'd0, 1'b1, 0, 42, 1, 4);
    tbl[4] = mk(4, All2, All2, All2, All2, 1'b0, 2, 48, 4, 10);
    tbl[5] = mk(4, 36'd7, 36'd7, 36'd7, 36'd7, 1'b0, 0, 28, 4, 7);

    #1 rst = 1'b1;
    #1;
    chk("rst_valid", int'(ov0), 0);
    chk("rst_data", int'(od0), 0);
    chk("rst_beats", int'(ob0), 0);
    chk("rst_valid_s", int'(ov1), 0);
    chk("rst_valid_odd", int'(ov2), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    for (int t = 0; t < 5; t++) run_group(tbl[t], $sformatf("grp%0d", t));

    // Async reset between edges with a full group still in the pipeline.
    for (int b = 0; b < 4; b++) step(1'b1, 1'b1, 1'b0, 36'd50);
    @(posedge clk);
    #1;
    v0 = 1'b0; l0 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", int'(ov0), 0);
    chk("arst_data", int'(od0), 0);
    chk("arst_beats", int'(ob0), 0);
    expq.delete();
    acc_m = 0;
    cnt_m = 0;
    #3 rst = 1'b0;
    run_group(tbl[5], "post_rst");

    // Random beats, lasts and stalls against the group model.
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom(), $urandom()};
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), rnd[35:0]);
    end
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, '0);
    chk("sb_drained", expq.size(), 0);

    // Signed ACC_LEN=1 and odd N_IN instances at full rate.
    for (int j = 0; j < 24; j++) begin
      rnd = {$urandom(), $urandom()};
      b1[j] = (j < 3) ? AllM32 : rnd[35:0];
      rnd = {$urandom(), $urandom()};
      b2[j] = (j == 0) ? {6'd5, 6'd4, 6'd3, 6'd2, 6'd1} : rnd[29:0];
      e1[j] = sum_s(b1[j]) & 32'h1FF;
      e2[j] = sum_u({6'd0, b2[j]}, 5);
    end
    chk("neg_ref", e1[0], 32'h140);
    for (int k = 0; k < 29; k++) begin
      @(posedge clk);
      #1;
      v1 = (k < 24); v2 = (k < 24);
      d1 = (k < 24) ? b1[k] : '0;
      d2 = (k < 24) ? b2[k] : '0;
      @(negedge clk);
      if (k < 5) begin
        chk("s_idle", int'(ov1), 0);
        chk("odd_idle", int'(ov2), 0);
      end else begin
        chk("s_valid", int'(ov1), 1);
        chk("s_data", int'(od1), e1[k-5]);
        chk("s_beats", int'(ob1), 1);
        chk("odd_valid", int'(ov2), 1);
        chk("odd_data", int'(od2), e2[k-5]);
        chk("odd_beats", int'(ob2), 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
